// File: rtl/dwt_pkg.sv
// Shared constants, width helpers and FSM encoding for the two-band
// wavelet analysis stage.
package dwt_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Full-precision accumulator width: product width plus growth for TAPS terms.
  function automatic int acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + clog2(taps);
  endfunction

  // Tap counter width, never narrower than one bit.
  function automatic int cnt_w(input int taps);
    return (clog2(taps) < 1) ? 1 : clog2(taps);
  endfunction

  // Daubechies-4 in Q8, tap k at [k*16 +: 16], tap 0 in the LSBs.
  // Lowpass taps 0..3: 124, 214, 57, -33
  localparam logic [63:0] D4_LO_Q8 = {16'hFFDF, 16'h0039, 16'h00D6, 16'h007C};
  // Highpass taps 0..3: -33, -57, 214, -124
  localparam logic [63:0] D4_HI_Q8 = {16'hFF84, 16'h00D6, 16'hFFC7, 16'hFFDF};

  // Valid/ready on both ports: a beat moves on a rising edge where both
  // valid and ready are high; valid never drops and data never changes
  // until that beat has moved.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/dwt_mac_lane.sv
// One band of the analysis stage: a single multiplier stepped over the taps,
// a full-precision accumulator, then round-half-up and saturation.
module dwt_mac_lane
  import dwt_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 4,
  parameter int FRAC   = 8,
  parameter int OUT_W  = 20,
  parameter logic [TAPS*COEF_W-1:0] COEFS = D4_LO_Q8,
  parameter int CNT_W  = cnt_w(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     step_i,
  input  logic [CNT_W-1:0]         tap_i,
  input  logic signed [DATA_W-1:0] sample_i,
  output logic signed [OUT_W-1:0]  res_o,
  output logic                     sat_o
);

  localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [ACC_W:0] HALF  = (ACC_W + 1)'(1) << (FRAC - 1);
  localparam logic signed [ACC_W:0] MAX_V = (ACC_W + 1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

  logic signed [COEF_W-1:0] coef_tab [TAPS];
  logic signed [COEF_W-1:0] coef;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W:0]    rnd;
  logic signed [ACC_W:0]    shifted;
  logic                     clip_hi;
  logic                     clip_lo;

  for (genvar k = 0; k < TAPS; k++) begin : g_coef
    assign coef_tab[k] = COEFS[k*COEF_W +: COEF_W];
  end

  assign coef  = coef_tab[tap_i];
  assign prod  = sample_i * coef;
  // Running sum including the current tap, so the final result is ready on the last step.
  assign acc_d = acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  // Round half up in one extra bit of headroom, then clip to the output range.
  always_comb begin
    rnd     = {acc_d[ACC_W-1], acc_d} + HALF;
    shifted = rnd >>> FRAC;
    clip_hi = (shifted > MAX_V);
    clip_lo = (shifted < MIN_V);
    if (clip_hi) begin
      res_o = MAX_V[OUT_W-1:0];
    end else if (clip_lo) begin
      res_o = MIN_V[OUT_W-1:0];
    end else begin
      res_o = shifted[OUT_W-1:0];
    end
    sat_o = clip_hi | clip_lo;
  end

  // Accumulator: cleared when a new output starts, one tap added per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (step_i) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/dwt_fir_decim.sv
// Two-band FIR analysis with decimate-by-2: every second accepted sample
// triggers TAPS multiply-accumulate cycles per band, then the rounded and
// saturated lo/hi pair is held until the consumer takes it.
module dwt_fir_decim
  import dwt_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 4,
  parameter int FRAC   = 8,
  parameter int OUT_W  = 20,
  parameter logic [TAPS*COEF_W-1:0] LO_COEFS = D4_LO_Q8,
  parameter logic [TAPS*COEF_W-1:0] HI_COEFS = D4_HI_Q8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [OUT_W-1:0]  out_lo,
  output logic signed [OUT_W-1:0]  out_hi,
  output logic                     out_sat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output state_e                   dbg_state_o
);

  localparam int CNT_W = cnt_w(TAPS);
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

  state_e                   state_q;
  state_e                   state_d;
  logic                     live_q;
  logic                     phase_q;
  logic [CNT_W-1:0]         cnt_q;
  logic signed [DATA_W-1:0] dl_q [TAPS];
  logic signed [OUT_W-1:0]  lo_q;
  logic signed [OUT_W-1:0]  hi_q;
  logic                     sat_q;
  logic                     xfer;
  logic                     start_mac;
  logic                     mac_step;
  logic                     last_tap;
  logic signed [OUT_W-1:0]  lo_res;
  logic signed [OUT_W-1:0]  hi_res;
  logic                     lo_sat;
  logic                     hi_sat;

  assign xfer      = in_valid & in_ready;
  assign start_mac = xfer & phase_q;
  assign last_tap  = (cnt_q == LAST_TAP);

  // State register; live_q keeps in_ready low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  // Next state: odd sample starts the MAC pass, last tap moves to HOLD, handshake returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_mac)       state_d = ST_MAC;
      ST_MAC:  if (last_tap)        state_d = ST_HOLD;
      ST_HOLD: if (out_ready)       state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Per-state outputs; in_ready depends only on registered state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mac_step  = 1'b0;
    unique case (state_q)
      ST_IDLE: in_ready  = live_q;
      ST_MAC:  mac_step  = 1'b1;
      ST_HOLD: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Delay line (tap 0 newest), phase bit and tap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) dl_q[k] <= '0;
      phase_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (xfer) begin
        dl_q[0] <= in_data;
        for (int k = 1; k < TAPS; k++) dl_q[k] <= dl_q[k-1];
        phase_q <= ~phase_q;
      end
      if (start_mac) begin
        cnt_q <= '0;
      end else if (mac_step) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Output registers load once on the last tap and stay frozen through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q  <= '0;
      hi_q  <= '0;
      sat_q <= 1'b0;
    end else if (mac_step && last_tap) begin
      lo_q  <= lo_res;
      hi_q  <= hi_res;
      sat_q <= lo_sat | hi_sat;
    end
  end

  dwt_mac_lane #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .FRAC(FRAC),
    .OUT_W(OUT_W), .COEFS(LO_COEFS), .CNT_W(CNT_W)
  ) u_lo (
    .clk(clk), .rst_n(rst_n), .clr_i(start_mac), .step_i(mac_step),
    .tap_i(cnt_q), .sample_i(dl_q[cnt_q]), .res_o(lo_res), .sat_o(lo_sat)
  );

  dwt_mac_lane #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .FRAC(FRAC),
    .OUT_W(OUT_W), .COEFS(HI_COEFS), .CNT_W(CNT_W)
  ) u_hi (
    .clk(clk), .rst_n(rst_n), .clr_i(start_mac), .step_i(mac_step),
    .tap_i(cnt_q), .sample_i(dl_q[cnt_q]), .res_o(hi_res), .sat_o(hi_sat)
  );

  assign out_lo      = lo_q;
  assign out_hi      = hi_q;
  assign out_sat     = sat_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dwt_fir_decim.sv
// Directed bench: impulse, DC, rounding, saturation (OUT_W=16 instance),
// backpressure with latency, and reset in the middle of a MAC pass.
module tb_dwt_fir_decim;
  import dwt_pkg::*;

  localparam int TAPS = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic signed [15:0] in_data = '0;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;

  logic               in_ready;
  logic signed [19:0] out_lo;
  logic signed [19:0] out_hi;
  logic               out_sat;
  logic               out_valid;
  state_e             dbg_state;

  logic               s_in_ready;
  logic signed [15:0] s_lo;
  logic signed [15:0] s_hi;
  logic               s_sat;
  logic               s_valid;
  state_e             s_state;

  int checks = 0;
  int errors = 0;

  dwt_fir_decim u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_lo(out_lo), .out_hi(out_hi), .out_sat(out_sat),
    .out_valid(out_valid), .out_ready(out_ready), .dbg_state_o(dbg_state)
  );

  dwt_fir_decim #(.OUT_W(16)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(s_in_ready), .out_lo(s_lo), .out_hi(s_hi), .out_sat(s_sat),
    .out_valid(s_valid), .out_ready(out_ready), .dbg_state_o(s_state)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; offers x until it is accepted.
  task automatic send(input logic signed [15:0] x);
    int t;
    t = 0;
    in_data  = x;
    in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("send_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Waits for an output beat and compares it; out_ready high consumes it.
  task automatic expect_out(input string tag, input int lo, input int hi,
                            input bit sat, input bit use_sat);
    int t;
    logic v;
    t = 0;
    @(negedge clk);
    v = use_sat ? s_valid : out_valid;
    while (!v && t < 100) begin
      @(negedge clk);
      t++;
      v = use_sat ? s_valid : out_valid;
    end
    check({tag, "_valid"}, v, 1);
    if (use_sat) begin
      check({tag, "_lo"}, s_lo, lo);
      check({tag, "_hi"}, s_hi, hi);
      check({tag, "_sat"}, s_sat, sat);
    end else begin
      check({tag, "_lo"}, out_lo, lo);
      check({tag, "_hi"}, out_hi, hi);
      check({tag, "_sat"}, out_sat, sat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic impulse_run(input string tag);
    send(16'sd256); send(16'sd0);
    expect_out({tag, "_o1"}, 214, -57, 1'b0, 1'b0);
    send(16'sd0); send(16'sd0);
    expect_out({tag, "_o2"}, -33, -124, 1'b0, 1'b0);
    send(16'sd0); send(16'sd0);
    expect_out({tag, "_o3"}, 0, 0, 1'b0, 1'b0);
  endtask

  // Safety net against a stuck design.
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    out_ready = 1'b1;
    do_reset();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_lo", out_lo, 0);
    check("post_rst_out_hi", out_hi, 0);
    check("post_rst_out_sat", out_sat, 0);
    check("post_rst_state", dbg_state, ST_IDLE);

    // Impulse response
    impulse_run("imp");

    // DC 1000
    do_reset();
    send(16'sd1000); send(16'sd1000);
    expect_out("dc_o1", 1320, -352, 1'b0, 1'b0);
    send(16'sd1000); send(16'sd1000);
    expect_out("dc_o2", 1414, 0, 1'b0, 1'b0);
    send(16'sd1000); send(16'sd1000);
    expect_out("dc_o3", 1414, 0, 1'b0, 1'b0);

    // Rounding with DC -1
    do_reset();
    send(-16'sd1); send(-16'sd1);
    expect_out("neg_o1", -1, 0, 1'b0, 1'b0);
    send(-16'sd1); send(-16'sd1);
    expect_out("neg_o2", -1, 0, 1'b0, 1'b0);

    // Saturation on the 16-bit output instance
    do_reset();
    send(16'sd32767); send(16'sd32767);
    expect_out("sat_o1", 32767, -11520, 1'b1, 1'b1);
    send(16'sd32767); send(16'sd32767);
    expect_out("sat_o2", 32767, 0, 1'b1, 1'b1);

    // Latency and backpressure
    do_reset();
    out_ready = 1'b0;
    send(16'sd256); send(16'sd0);
    for (int i = 1; i <= TAPS; i++) begin
      if (i < TAPS) begin
        check("lat_not_yet", out_valid, 0);
      end
      @(posedge clk);
      #1;
    end
    check("lat_valid", out_valid, 1);
    check("bp_lo", out_lo, 214);
    check("bp_hi", out_hi, -57);
    in_data  = 16'sd5000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_lo", out_lo, 214);
      check("bp_hold_hi", out_hi, -57);
      check("bp_hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_state", dbg_state, ST_IDLE);
    send(16'sd0); send(16'sd0);
    expect_out("bp_next", -33, -124, 1'b0, 1'b0);

    // Reset during tap 2 of a MAC pass
    send(16'sd256); send(16'sd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_state_mac", dbg_state, ST_MAC);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_state", dbg_state, ST_IDLE);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    impulse_run("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
